// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the MIPS fetch stage: reset constants, pending-redirect
// state encoding and a word-alignment helper.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    PEND_IDLE = 2'd0,
    PEND_HELD = 2'd1
  } pend_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_npc_mux.sv
// Next-PC selector: a live redirect beats a buffered one, which beats PC+4.
module npc_mux
  import fetch_stage_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        pending,
  input  logic [31:0] pending_target,
  output logic [31:0] npc
);

  always_comb begin
    if (redirect_valid) begin
      npc = word_align(redirect_target);
    end else if (pending) begin
      npc = word_align(pending_target);
    end else begin
      npc = pc + PC_STEP;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, stalled-redirect buffer and the
// F/D pipeline register feeding decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = fetch_stage_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        flush_d,
  input  logic [31:0] im_rdata,
  output logic [31:0] im_addr,
  output logic [31:0] pc_F,
  output logic [31:0] IR_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC4_D,
  output logic        valid_D,
  output logic        redirect_pending
);
  import fetch_stage_pkg::*;

  pend_state_t pend_state_reg, pend_state_next;
  logic [31:0] pend_target_reg;
  logic        pending;
  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic [31:0] ir_reg, pcd_reg, pc4d_reg;
  logic        valid_reg;

  npc_mux u_npc_mux (
    .pc              (pc_reg),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pending         (pending),
    .pending_target  (pend_target_reg),
    .npc             (pc_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_state_reg <= PEND_IDLE;
    end else begin
      pend_state_reg <= pend_state_next;
    end
  end

  always_comb begin
    pend_state_next = pend_state_reg;
    case (pend_state_reg)
      PEND_IDLE: if (stall && redirect_valid) pend_state_next = PEND_HELD;
      PEND_HELD: if (!stall) pend_state_next = PEND_IDLE;
      default:   pend_state_next = PEND_IDLE;
    endcase
  end

  always_comb begin
    pending = (pend_state_reg == PEND_HELD);
  end

  // Latest redirect seen during a stall wins; applied on the first unstalled edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_target_reg <= '0;
    end else if (stall && redirect_valid) begin
      pend_target_reg <= redirect_target;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg <= RESET_PC;
    end else if (!stall) begin
      pc_reg <= pc_next;
    end
  end

  // Flush overrides the stall hold on the F/D register only; the PC is unaffected.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_reg    <= NOP_INSTR;
      pcd_reg   <= '0;
      pc4d_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (flush_d) begin
      ir_reg    <= NOP_INSTR;
      pcd_reg   <= '0;
      pc4d_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (!stall) begin
      ir_reg    <= im_rdata;
      pcd_reg   <= pc_reg;
      pc4d_reg  <= pc_reg + PC_STEP;
      valid_reg <= 1'b1;
    end
  end

  assign im_addr          = pc_reg;
  assign pc_F             = pc_reg;
  assign IR_D             = ir_reg;
  assign PC_D             = pcd_reg;
  assign PC4_D            = pc4d_reg;
  assign valid_D          = valid_reg;
  assign redirect_pending = pending;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, reset corner case,
// then randomized stimulus against a behavioural model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, redirect_valid, flush_d;
  logic [31:0] redirect_target;
  logic [31:0] im_rdata, im_addr, pc_F, IR_D, PC_D, PC4_D;
  logic        valid_D, redirect_pending;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] im_word(input logic [31:0] a);
    return a ^ 32'hC3C3_0000;
  endfunction

  assign im_rdata = im_word(im_addr);

  fetch_stage dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .flush_d          (flush_d),
    .im_rdata         (im_rdata),
    .im_addr          (im_addr),
    .pc_F             (pc_F),
    .IR_D             (IR_D),
    .PC_D             (PC_D),
    .PC4_D            (PC4_D),
    .valid_D          (valid_D),
    .redirect_pending (redirect_pending)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input logic [31:0] e_pc, input logic [31:0] e_ir,
                         input logic [31:0] e_pcd, input logic [31:0] e_pc4,
                         input logic e_v, input logic e_p);
    chk("pc_F", pc_F, e_pc);
    chk("im_addr", im_addr, e_pc);
    chk("IR_D", IR_D, e_ir);
    chk("PC_D", PC_D, e_pcd);
    chk("PC4_D", PC4_D, e_pc4);
    chk("valid_D", {31'b0, valid_D}, {31'b0, e_v});
    chk("redirect_pending", {31'b0, redirect_pending}, {31'b0, e_p});
  endtask

  typedef struct packed {
    logic        stall;
    logic        rv;
    logic [31:0] tgt;
    logic        flush;
    logic [31:0] e_pc;
    logic [31:0] e_pcd;
    logic        e_v;
    logic        e_p;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  // Behavioural model state
  logic [31:0] m_pc, m_ir, m_pcd, m_pc4, m_tgt;
  logic        m_v, m_p;

  task automatic model_edge();
    logic [31:0] npc;
    if (!stall) begin
      if (redirect_valid)  npc = redirect_target & ~32'd3;
      else if (m_p)        npc = m_tgt & ~32'd3;
      else                 npc = m_pc + 32'd4;
      m_ir  = im_word(m_pc);
      m_pcd = m_pc;
      m_pc4 = m_pc + 32'd4;
      m_v   = 1'b1;
      m_p   = 1'b0;
      m_pc  = npc;
    end else if (redirect_valid) begin
      m_p   = 1'b1;
      m_tgt = redirect_target;
    end
    if (flush_d) begin
      m_ir  = 32'h0;
      m_pcd = 32'h0;
      m_pc4 = 32'h0;
      m_v   = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] e_ir, e_pc4;

    vecs[0]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h3004,      32'h3000,      1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h3008,      32'h3004,      1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h3008,      32'h3004,      1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h3008,      32'h3004,      1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h3008,      32'h3004,      1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h300C,      32'h3008,      1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h3010,      32'h300C,      1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 32'h3040,      1'b0, 32'h3040,      32'h3010,      1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h3044,      32'h3040,      1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 32'h3080,      1'b0, 32'h3044,      32'h3040,      1'b1, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 32'h3100,      1'b0, 32'h3044,      32'h3040,      1'b1, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h3044,      32'h3040,      1'b1, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h3100,      32'h3044,      1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h3104,      32'h3100,      1'b1, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h3104,      32'h0,         1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h3108,      32'h3104,      1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 32'h3043,      1'b0, 32'h3040,      32'h3108,      1'b1, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 32'h3040,      1'b1, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'hFFFF_FFFC, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h4,         32'h0,         1'b1, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8,         32'h0,         1'b0, 1'b0};
    vecs[21] = '{1'b1, 1'b1, 32'h3200,      1'b0, 32'h8,         32'h0,         1'b0, 1'b1};
    vecs[22] = '{1'b0, 1'b1, 32'h3300,      1'b0, 32'h3300,      32'h8,         1'b1, 1'b0};

    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    redirect_target = '0; flush_d = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all(32'h3000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    $display("reset: pc_F=%h IR_D=%h valid_D=%b", pc_F, IR_D, valid_D);
    reset = 1'b1;

    // Directed table
    for (int i = 0; i < NVEC; i++) begin
      stall = vecs[i].stall; redirect_valid = vecs[i].rv;
      redirect_target = vecs[i].tgt; flush_d = vecs[i].flush;
      @(posedge clk);
      #1;
      e_ir  = vecs[i].e_v ? im_word(vecs[i].e_pcd) : 32'h0;
      e_pc4 = vecs[i].e_v ? vecs[i].e_pcd + 32'd4 : 32'h0;
      chk_all(vecs[i].e_pc, e_ir, vecs[i].e_pcd, e_pc4, vecs[i].e_v, vecs[i].e_p);
      $display("vec %0d: stall=%b rv=%b tgt=%h flush=%b -> pc_F=%h PC_D=%h IR_D=%h pend=%b",
               i, stall, redirect_valid, redirect_target, flush_d, pc_F, PC_D, IR_D, redirect_pending);
    end

    // Reset pulsed mid-stall with a redirect pending: must act without a clock edge
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h3500; flush_d = 1'b0;
    @(posedge clk);
    #1;
    chk("pend_before_reset", {31'b0, redirect_pending}, 32'd1);
    redirect_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk_all(32'h3000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    $display("async reset mid-stall: pc_F=%h pend=%b", pc_F, redirect_pending);
    #1 reset = 1'b1;
    stall = 1'b0;
    @(posedge clk);
    #1;
    chk_all(32'h3004, im_word(32'h3000), 32'h3000, 32'h3004, 1'b1, 1'b0);
    $display("after reset release: pc_F=%h IR_D=%h pend=%b", pc_F, IR_D, redirect_pending);

    // Randomized phase against the behavioural model
    m_pc = 32'h3004; m_ir = im_word(32'h3000); m_pcd = 32'h3000; m_pc4 = 32'h3004;
    m_v = 1'b1; m_p = 1'b0; m_tgt = 32'h0;
    for (int n = 0; n < 300; n++) begin
      stall           = ($urandom_range(0, 2) == 0);
      redirect_valid  = ($urandom_range(0, 4) == 0);
      redirect_target = $urandom;
      flush_d         = ($urandom_range(0, 7) == 0);
      model_edge();
      @(posedge clk);
      #1;
      chk_all(m_pc, m_ir, m_pcd, m_pc4, m_v, m_p);
      $display("rand %0d: stall=%b rv=%b tgt=%h flush=%b -> pc_F=%h PC_D=%h pend=%b",
               n, stall, redirect_valid, redirect_target, flush_d, pc_F, PC_D, redirect_pending);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline (F stage plus the F/D pipeline register).
- Owns the PC and addresses instruction memory.
- Launches IR, PC and PC4 into the decode stage; the decode stage consumes them and returns stall and redirect information.
- Buffers a branch/jump redirect that arrives while the pipeline is stalled, so it is never lost.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset; also the first fetch address.
- NOP_INSTR, 32'h0000_0000, instruction word injected into IR_D on reset and flush.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- stall  in  1  hazard-unit stall; 1 = hold PC and F/D register.
- redirect_valid  in  1  decode stage resolved a taken branch / j / jal / jr this cycle.
- redirect_target  in  32  byte address of redirect target.
- flush_d  in  1  load NOP_INSTR into the F/D register at the next edge.
- im_rdata  in  32  instruction word at im_addr (combinational IM read).
- im_addr  out  32  fetch address; equals pc_F.
- pc_F  out  32  current fetch PC.
- IR_D  out  32  registered instruction for decode.
- PC_D  out  32  registered PC of IR_D.
- PC4_D  out  32  registered PC_D+4.
- valid_D  out  1  IR_D holds a fetched (non-bubble) instruction.
- redirect_pending  out  1  a buffered redirect is waiting to be applied.

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately):
  - pc_F=RESET_PC, IR_D=NOP_INSTR, PC_D=0, PC4_D=0, valid_D=0.
  - Pending flag=0, pending target=0.
- On release of reset, the first edge captures im_rdata at RESET_PC into IR_D.
- Delayed-branch MIPS: the instruction after a branch (delay slot) is always fetched and never flushed by redirect.
- Next-PC selection, evaluated every edge with stall=0, first match wins:
  1. redirect_valid=1 → redirect_target.
  2. pending=1 → pending target.
  3. otherwise → pc_F+4.
- Target bits [1:0] are forced to 00 before use.
- All PC arithmetic is 32-bit modular: 32'hFFFF_FFFC+4 = 0, no error.
- stall=0 edge:
  - pc_F <= next PC.
  - IR_D <= im_rdata, PC_D <= pc_F, PC4_D <= pc_F+4, valid_D <= 1.
  - Pending flag cleared.
- stall=1 edge:
  - pc_F, IR_D, PC_D, PC4_D and valid_D hold.
  - If redirect_valid=1: pending flag <= 1 and pending target <= redirect_target. A newer redirect overwrites an older pending one.
- flush_d=1 edge, regardless of stall:
  - IR_D <= NOP_INSTR, PC_D <= 0, PC4_D <= 0, valid_D <= 0.
  - pc_F follows the stall rule independently.
- Pending buffer state machine:
  - States: IDLE, HELD.
  - IDLE→HELD when stall=1 and redirect_valid=1.
  - HELD→HELD while stall=1; target is updated on any new redirect.
  - HELD→IDLE on the first stall=0 edge, where the target (or a simultaneous live redirect) is applied.
- Latency:
  - Redirect with stall=0 changes pc_F one edge later.
  - IR_D reflects the new target's instruction two edges after the redirect.
- Reset asserted mid-stall or with a pending redirect discards the pending redirect; fetch restarts at RESET_PC.
- No combinational path from stall/redirect to IR_D/PC_D/PC4_D/valid_D. im_addr is purely registered.

Decomposition:
- Shared pipeline package holds RESET_PC, NOP_INSTR and the 2-bit pending-state encoding (IDLE=0, HELD=1).
- One natural sub-module: npc_mux, the combinational next-PC selector (redirect / pending / PC+4, with alignment masking).
- The PC register, pending buffer and F/D register stay in fetch_stage.

Test Plan:
- Reset then 4 free-running cycles, IM returning addr-tagged words → pc_F 3000,3004,3008,300C,3010; IR_D/PC_D track one cycle behind; PC4_D=PC_D+4; valid_D 0 then 1.
- stall=1 for 3 cycles at pc_F=3008 → pc_F, IR_D, PC_D frozen for 3 edges; on release pc_F=300C, IR_D=word@3008.
- redirect_valid=1, target 0000_3040, stall=0, at pc_F=3010 → next pc_F=3040; IR_D=word@3010 (delay slot) then word@3040.
- redirect target 3080 during stall=1, then target 3100 still in stall, then release → redirect_pending=1 during stall; after release pc_F=3100, redirect_pending=0.
- flush_d=1 with stall=1 → IR_D=0, valid_D=0, PC_D=0; pc_F unchanged.
- reset pulsed low mid-stall with redirect pending → outputs at reset values immediately (no clock edge needed); after release pc_F=3000, redirect_pending=0.
- Target 0000_3043 → pc_F=3040.
- PC wrap from FFFF_FFFC → 0000_0000.
